// File: rtl/main_mem_responder_if.sv
// Request/grant bus between the data cache refill/writeback logic and the
// line-granular backing memory.
interface main_mem_responder_if #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int MEM_ADDR_LEN  = 9
);
    localparam int LINE_W = 32 * (2 ** LINE_ADDR_LEN);

    logic                    rd_req;
    logic                    wr_req;
    logic [MEM_ADDR_LEN-1:0] addr;
    logic [LINE_W-1:0]       wr_line;
    logic [LINE_W-1:0]       rd_line;
    logic                    gnt;
    logic                    busy;
    logic [31:0]             rd_count;
    logic [31:0]             wr_count;

    modport master (
        output rd_req, wr_req, addr, wr_line,
        input  rd_line, gnt, busy, rd_count, wr_count
    );

    modport slave (
        input  rd_req, wr_req, addr, wr_line,
        output rd_line, gnt, busy, rd_count, wr_count
    );
endinterface

// File: rtl/main_mem_responder.sv
// Backing memory for the data cache: serialized line reads/writes with a fixed
// programmable latency, one-cycle grant and read/write transaction counters.
module main_mem_responder #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int MEM_ADDR_LEN  = 9,
    parameter int RD_CYCLE      = 50,
    parameter int WR_CYCLE      = 50
) (
    input logic                 clk,
    input logic                 rst_n,
    main_mem_responder_if.slave bus
);
    localparam int LINE_W = 32 * (2 ** LINE_ADDR_LEN);
    localparam int DEPTH  = 2 ** MEM_ADDR_LEN;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] READ  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]              state;
    logic [31:0]             cnt;
    logic [MEM_ADDR_LEN-1:0] addr_q;
    logic [LINE_W-1:0]       line_q;
    logic [LINE_W-1:0]       rd_line_q;
    logic [31:0]             rd_count_q;
    logic [31:0]             wr_count_q;
    logic                    commit_wr;

    logic [LINE_W-1:0] mem [DEPTH];

    // A reset drops the state to IDLE asynchronously, so an aborted write never commits.
    assign commit_wr = (state == WRITE) && (cnt == 32'd0);

    always_ff @(posedge clk) begin
        if (commit_wr) begin
            mem[addr_q] <= line_q;
        end
    end

    // Operands are latched on acceptance so the requester may change them freely afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 32'd0;
            addr_q     <= '0;
            line_q     <= '0;
            rd_line_q  <= '0;
            rd_count_q <= 32'd0;
            wr_count_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.wr_req) begin
                        addr_q <= bus.addr;
                        line_q <= bus.wr_line;
                        cnt    <= 32'(WR_CYCLE - 1);
                        state  <= WRITE;
                    end else if (bus.rd_req) begin
                        addr_q <= bus.addr;
                        cnt    <= 32'(RD_CYCLE - 1);
                        state  <= READ;
                    end
                end
                WRITE: begin
                    if (cnt != 32'd0) begin
                        cnt <= cnt - 32'd1;
                    end else begin
                        wr_count_q <= wr_count_q + 32'd1;
                        state      <= DONE;
                    end
                end
                READ: begin
                    if (cnt != 32'd0) begin
                        cnt <= cnt - 32'd1;
                    end else begin
                        rd_line_q  <= mem[addr_q];
                        rd_count_q <= rd_count_q + 32'd1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt      = (state == DONE);
    assign bus.busy     = (state != IDLE);
    assign bus.rd_line  = rd_line_q;
    assign bus.rd_count = rd_count_q;
    assign bus.wr_count = wr_count_q;
endmodule

// File: tb/tb_main_mem_responder.sv
// Self-checking bench: a slow instance (RD=50, WR=40) and a fast one (RD=WR=1),
// compared against an associative-array memory model with expected counters.
module tb_main_mem_responder;
    localparam int LW = 256;
    typedef logic [LW-1:0] line_t;

    typedef struct packed {
        logic        gnt;
        logic        busy;
        line_t       rd_line;
        logic [31:0] rd_count;
        logic [31:0] wr_count;
    } obs_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    main_mem_responder_if #(.LINE_ADDR_LEN(3), .MEM_ADDR_LEN(9)) si ();
    main_mem_responder_if #(.LINE_ADDR_LEN(3), .MEM_ADDR_LEN(9)) fi ();

    main_mem_responder #(.LINE_ADDR_LEN(3), .MEM_ADDR_LEN(9), .RD_CYCLE(50), .WR_CYCLE(40)) dut_slow (
        .clk(clk), .rst_n(rst_n), .bus(si));
    main_mem_responder #(.LINE_ADDR_LEN(3), .MEM_ADDR_LEN(9), .RD_CYCLE(1), .WR_CYCLE(1)) dut_fast (
        .clk(clk), .rst_n(rst_n), .bus(fi));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: line contents per address, expected counters and last read line.
    line_t       mem_s [int];
    line_t       mem_f [int];
    int unsigned exp_rd [2];
    int unsigned exp_wr [2];
    line_t       last_rd [2];

    function automatic int rd_lat(input bit f);
        return f ? 1 : 50;
    endfunction

    function automatic int wr_lat(input bit f);
        return f ? 1 : 40;
    endfunction

    function automatic line_t make_line(input logic [31:0] base, input bit incr);
        line_t l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = incr ? base + 32'(i) : base;
        return l;
    endfunction

    function automatic line_t rand_line();
        line_t l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    function automatic bit model_has(input bit f, input int a);
        return f ? mem_f.exists(a) : mem_s.exists(a);
    endfunction

    function automatic void model_commit(input bit f, input bit wr, input int a, input line_t d);
        if (wr) begin
            if (f) mem_f[a] = d; else mem_s[a] = d;
            exp_wr[f]++;
        end else begin
            last_rd[f] = f ? mem_f[a] : mem_s[a];
            exp_rd[f]++;
        end
    endfunction

    function automatic void model_reset();
        for (int f = 0; f < 2; f++) begin
            exp_rd[f]  = 0;
            exp_wr[f]  = 0;
            last_rd[f] = '0;
        end
    endfunction

    task automatic drive(input bit f, input logic rd, input logic wr, input logic [8:0] a, input line_t d);
        if (f) begin
            fi.rd_req = rd; fi.wr_req = wr; fi.addr = a; fi.wr_line = d;
        end else begin
            si.rd_req = rd; si.wr_req = wr; si.addr = a; si.wr_line = d;
        end
    endtask

    function automatic obs_t observe(input bit f);
        obs_t o;
        if (f) o = '{fi.gnt, fi.busy, fi.rd_line, fi.rd_count, fi.wr_count};
        else   o = '{si.gnt, si.busy, si.rd_line, si.rd_count, si.wr_count};
        return o;
    endfunction

    // Runs one request to completion; lat counts edges from the accepting edge to gnt.
    task automatic do_txn(input bit f, input bit wr, input logic [8:0] a, input line_t d,
                          output int lat, output obs_t at_gnt, output logic gnt_after, output bit ok);
        obs_t o;
        lat    = -1;
        ok     = 1'b0;
        at_gnt = '0;
        drive(f, !wr, wr, a, d);
        for (int k = 0; k < 200 && !ok; k++) begin
            @(posedge clk); #1;
            lat++;
            o = observe(f);
            if (o.gnt === 1'b1) begin
                ok     = 1'b1;
                at_gnt = o;
            end
        end
        drive(f, 1'b0, 1'b0, a, d);
        @(posedge clk); #1;
        o = observe(f);
        gnt_after = o.gnt;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        obs_t o;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        for (int f = 0; f < 2; f++) begin
            o = observe(f[0]);
            checks++; if ({o.gnt, o.busy} !== 2'b00) begin failures++; $display("[TB] FAIL reset_gnt_busy inst=%0d got=%b exp=00", f, {o.gnt, o.busy}); end
            checks++; if (o.rd_line !== '0) begin failures++; $display("[TB] FAIL reset_rd_line inst=%0d got=%h exp=0", f, o.rd_line); end
            checks++; if ({o.rd_count, o.wr_count} !== 64'd0) begin failures++; $display("[TB] FAIL reset_counts inst=%0d got=%0d/%0d exp=0/0", f, o.rd_count, o.wr_count); end
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_read_latency();
        int lat; obs_t o; logic ga; bit ok;
        line_t la;
        la = make_line(32'hA000_0000, 1'b1);
        reset_pulse();
        do_txn(1'b0, 1'b1, 9'd5, la, lat, o, ga, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL preload5_gnt got=%0b exp=1", ok); end
        model_commit(1'b0, 1'b1, 5, la);
        reset_pulse();
        do_txn(1'b0, 1'b0, 9'd5, '0, lat, o, ga, ok);
        model_commit(1'b0, 1'b0, 5, '0);
        checks++; if (lat !== 50) begin failures++; $display("[TB] FAIL read_latency got=%0d exp=50", lat); end
        checks++; if (ga !== 1'b0) begin failures++; $display("[TB] FAIL read_gnt_width got=%b exp=0", ga); end
        checks++; if (o.rd_line[3*32 +: 32] !== 32'hA000_0003) begin failures++; $display("[TB] FAIL read_word3 got=%h exp=a0000003", o.rd_line[3*32 +: 32]); end
        checks++; if (o.rd_line !== last_rd[0]) begin failures++; $display("[TB] FAIL read_line got=%h exp=%h", o.rd_line, last_rd[0]); end
        checks++; if (o.rd_count !== 32'(exp_rd[0]) || o.wr_count !== 32'(exp_wr[0])) begin failures++; $display("[TB] FAIL read_counts got=%0d/%0d exp=%0d/%0d", o.rd_count, o.wr_count, exp_rd[0], exp_wr[0]); end
    endtask

    task automatic test_write_read();
        int lat; obs_t o; logic ga; bit ok;
        line_t lb;
        lb = make_line(32'hDEAD_BEEF, 1'b0);
        reset_pulse();
        do_txn(1'b0, 1'b1, 9'd9, lb, lat, o, ga, ok);
        model_commit(1'b0, 1'b1, 9, lb);
        checks++; if (lat !== 40) begin failures++; $display("[TB] FAIL write_latency got=%0d exp=40", lat); end
        checks++; if (o.rd_line !== last_rd[0]) begin failures++; $display("[TB] FAIL write_keeps_rd_line got=%h exp=%h", o.rd_line, last_rd[0]); end
        do_txn(1'b0, 1'b0, 9'd9, '0, lat, o, ga, ok);
        model_commit(1'b0, 1'b0, 9, '0);
        checks++; if (o.rd_line !== lb) begin failures++; $display("[TB] FAIL write_then_read got=%h exp=%h", o.rd_line, lb); end
        checks++; if (o.rd_count !== 32'd1 || o.wr_count !== 32'd1) begin failures++; $display("[TB] FAIL write_read_counts got=%0d/%0d exp=1/1", o.rd_count, o.wr_count); end
    endtask

    task automatic test_simultaneous();
        obs_t o; int n; bit got;
        line_t d;
        d = rand_line();
        reset_pulse();
        drive(1'b0, 1'b1, 1'b1, 9'd2, d);
        n = 0; got = 1'b0;
        while (!got && n < 200) begin
            @(posedge clk); #1; n++;
            o = observe(1'b0);
            if (o.gnt === 1'b1) got = 1'b1;
        end
        model_commit(1'b0, 1'b1, 2, d);
        checks++; if (n !== 1 + wr_lat(1'b0)) begin failures++; $display("[TB] FAIL simul_first_gnt got=%0d exp=%0d", n, 1 + wr_lat(1'b0)); end
        checks++; if (o.wr_count !== 32'd1 || o.rd_count !== 32'd0) begin failures++; $display("[TB] FAIL simul_write_first got=%0d/%0d exp=0/1", o.rd_count, o.wr_count); end
        drive(1'b0, 1'b1, 1'b0, 9'd2, d);
        n = 0; got = 1'b0;
        while (!got && n < 200) begin
            @(posedge clk); #1; n++;
            o = observe(1'b0);
            if (o.gnt === 1'b1) got = 1'b1;
        end
        model_commit(1'b0, 1'b0, 2, '0);
        drive(1'b0, 1'b0, 1'b0, 9'd2, d);
        @(posedge clk); #1;
        checks++; if (n !== 2 + rd_lat(1'b0)) begin failures++; $display("[TB] FAIL simul_second_gnt got=%0d exp=%0d", n, 2 + rd_lat(1'b0)); end
        checks++; if (o.rd_line !== last_rd[0]) begin failures++; $display("[TB] FAIL simul_read_data got=%h exp=%h", o.rd_line, last_rd[0]); end
        checks++; if (o.rd_count !== 32'd1) begin failures++; $display("[TB] FAIL simul_rd_count got=%0d exp=1", o.rd_count); end
    endtask

    task automatic test_abort();
        int lat; obs_t o; logic ga; bit ok; int seen;
        line_t lo;
        lo = make_line(32'h1111_1111, 1'b0);
        reset_pulse();
        do_txn(1'b0, 1'b1, 9'd7, lo, lat, o, ga, ok);
        model_commit(1'b0, 1'b1, 7, lo);
        reset_pulse();
        drive(1'b0, 1'b0, 1'b1, 9'd7, rand_line());
        @(posedge clk);
        repeat (20) @(posedge clk);
        #1;
        o = observe(1'b0);
        checks++; if (o.busy !== 1'b1) begin failures++; $display("[TB] FAIL abort_busy_before got=%b exp=1", o.busy); end
        #2;
        rst_n = 1'b0;
        #1;
        o = observe(1'b0);
        checks++; if ({o.busy, o.gnt} !== 2'b00) begin failures++; $display("[TB] FAIL abort_immediate got=%b exp=00", {o.busy, o.gnt}); end
        drive(1'b0, 1'b0, 1'b0, 9'd0, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        seen = 0;
        repeat (60) begin
            @(posedge clk); #1;
            o = observe(1'b0);
            if (o.gnt !== 1'b0) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("[TB] FAIL abort_no_gnt got=%0d exp=0", seen); end
        checks++; if (o.wr_count !== 32'd0) begin failures++; $display("[TB] FAIL abort_wr_count got=%0d exp=0", o.wr_count); end
        do_txn(1'b0, 1'b0, 9'd7, '0, lat, o, ga, ok);
        model_commit(1'b0, 1'b0, 7, '0);
        checks++; if (o.rd_line !== lo) begin failures++; $display("[TB] FAIL abort_old_data got=%h exp=%h", o.rd_line, lo); end
    endtask

    task automatic test_latching();
        int lat; obs_t o; logic ga; bit ok;
        line_t da; line_t db;
        da = rand_line();
        db = rand_line();
        reset_pulse();
        do_txn(1'b1, 1'b1, 9'd20, db, lat, o, ga, ok);
        model_commit(1'b1, 1'b1, 20, db);
        checks++; if (lat !== 1) begin failures++; $display("[TB] FAIL fast_write_latency got=%0d exp=1", lat); end
        drive(1'b1, 1'b0, 1'b1, 9'd3, da);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 9'd20, ~da);
        o = observe(1'b1);
        checks++; if ({o.busy, o.gnt} !== 2'b10) begin failures++; $display("[TB] FAIL latch_busy_after_accept got=%b exp=10", {o.busy, o.gnt}); end
        @(posedge clk); #1;
        o = observe(1'b1);
        model_commit(1'b1, 1'b1, 3, da);
        checks++; if (o.gnt !== 1'b1) begin failures++; $display("[TB] FAIL latch_gnt_next_cycle got=%b exp=1", o.gnt); end
        @(posedge clk); #1;
        do_txn(1'b1, 1'b0, 9'd3, '0, lat, o, ga, ok);
        model_commit(1'b1, 1'b0, 3, '0);
        checks++; if (o.rd_line !== last_rd[1]) begin failures++; $display("[TB] FAIL latch_orig_addr got=%h exp=%h", o.rd_line, last_rd[1]); end
        do_txn(1'b1, 1'b0, 9'd20, '0, lat, o, ga, ok);
        model_commit(1'b1, 1'b0, 20, '0);
        checks++; if (o.rd_line !== last_rd[1]) begin failures++; $display("[TB] FAIL latch_other_untouched got=%h exp=%h", o.rd_line, last_rd[1]); end
    endtask

    task automatic test_random(input bit f, input int n_txn);
        int lat; obs_t o; logic ga; bit ok;
        bit wr; int a; line_t d; int exp_lat;
        for (int t = 0; t < n_txn; t++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            a  = $urandom_range(0, 15);
            wr = ($urandom_range(0, 1) == 1) || !model_has(f, a);
            d  = rand_line();
            exp_lat = wr ? wr_lat(f) : rd_lat(f);
            do_txn(f, wr, 9'(a), d, lat, o, ga, ok);
            model_commit(f, wr, a, d);
            checks++; if (ok !== 1'b1 || lat !== exp_lat || ga !== 1'b0) begin failures++; $display("[TB] FAIL rand_handshake inst=%0d t=%0d got=ok%0b lat%0d after%b exp=ok1 lat%0d after0", f, t, ok, lat, ga, exp_lat); end
            checks++; if (o.rd_line !== last_rd[f]) begin failures++; $display("[TB] FAIL rand_rd_line inst=%0d t=%0d got=%h exp=%h", f, t, o.rd_line, last_rd[f]); end
            checks++; if (o.rd_count !== 32'(exp_rd[f]) || o.wr_count !== 32'(exp_wr[f])) begin failures++; $display("[TB] FAIL rand_counts inst=%0d t=%0d got=%0d/%0d exp=%0d/%0d", f, t, o.rd_count, o.wr_count, exp_rd[f], exp_wr[f]); end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 9'd0, '0);
        drive(1'b1, 1'b0, 1'b0, 9'd0, '0);
        model_reset();
        test_reset();
        test_read_latency();
        test_write_read();
        test_simultaneous();
        test_abort();
        test_latching();
        test_random(1'b1, 150);
        test_random(1'b0, 20);
        test_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
